// File: rtl/button_conditioner_if.sv
// Raw push-button inputs and conditioned press pulses / debounced levels.
// The DUT side uses the slave modport.
interface button_conditioner_if;
  logic       left;
  logic       right;
  logic       up;
  logic       down;
  logic       sel;
  logic       left_p;
  logic       right_p;
  logic       up_p;
  logic       down_p;
  logic       sel_p;
  logic [4:0] btn_state;

  modport master (
    output left, right, up, down, sel,
    input  left_p, right_p, up_p, down_p, sel_p, btn_state
  );

  modport slave (
    input  left, right, up, down, sel,
    output left_p, right_p, up_p, down_p, sel_p, btn_state
  );
endinterface

// File: rtl/button_conditioner.sv
// Five-channel push-button conditioner: 2-flop sync, debounce, press pulse and
// auto-repeat on the direction buttons. Channel order {sel,down,up,right,left}.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_DELAY    = 12500000,
  parameter int unsigned REPEAT_RATE     = 5000000,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input logic                 clk,
  input logic                 reset,
  button_conditioner_if.slave btn
);

  localparam int unsigned NCH    = 5;
  localparam int unsigned CH_L   = 0;
  localparam int unsigned CH_R   = 1;
  localparam int unsigned CH_U   = 2;
  localparam int unsigned CH_D   = 3;
  localparam int unsigned CH_SEL = 4;

  localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW   = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT,
    HELD
  } state_e;

  logic [NCH-1:0] raw;
  logic [NCH-1:0] s1_q, s1_d;
  logic [NCH-1:0] s2_q, s2_d;
  logic [NCH-1:0] stable_q, stable_d;
  logic [NCH-1:0] rise, fall;
  logic [NCH-1:0] fire_q, fire_d;
  logic [NCH-1:0] pulse_q, pulse_d;
  logic [DW-1:0]  dcnt_q [NCH];
  logic [DW-1:0]  dcnt_d [NCH];
  logic [RW-1:0]  rcnt_q [NCH];
  logic [RW-1:0]  rcnt_d [NCH];
  state_e         state_q [NCH];
  state_e         state_d [NCH];

  assign raw = {btn.sel, btn.down, btn.up, btn.right, btn.left};

  assign s1_d = raw;
  assign s2_d = s1_q;

  // Debounce: accept s2 once it has differed from stable for DEBOUNCE_CYCLES samples.
  always_comb begin
    stable_d = stable_q;
    rise     = '0;
    fall     = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      dcnt_d[i] = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (dcnt_q[i] == DB_LAST) begin
          stable_d[i] = s2_q[i];
          rise[i]     = s2_q[i];
          fall[i]     = ~s2_q[i];
        end else if (dcnt_q[i] < DB_LAST) begin
          dcnt_d[i] = dcnt_q[i] + 1'b1;
        end else begin
          dcnt_d[i] = dcnt_q[i];
        end
      end
    end
  end

  // Per-channel press/repeat FSM. The repeat counter is held at zero during the
  // cycle its own pulse is visible, so consecutive pulses are REPEAT_RATE+1 apart.
  always_comb begin
    fire_d = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      rcnt_d[i]  = rcnt_q[i];
      unique case (state_q[i])
        IDLE: begin
          if (rise[i]) begin
            fire_d[i]  = 1'b1;
            rcnt_d[i]  = '0;
            state_d[i] = (REPEAT_EN && (i != CH_SEL)) ? DELAY : HELD;
          end
        end
        DELAY, REPEAT: begin
          if (fall[i]) begin
            rcnt_d[i]  = '0;
            state_d[i] = IDLE;
          end else if (fire_q[i]) begin
            rcnt_d[i] = '0;
          end else if (rcnt_q[i] == ((state_q[i] == DELAY) ? DLY_LAST : RATE_LAST)) begin
            fire_d[i]  = 1'b1;
            rcnt_d[i]  = '0;
            state_d[i] = REPEAT;
          end else begin
            rcnt_d[i] = rcnt_q[i] + 1'b1;
          end
        end
        HELD: begin
          if (fall[i]) begin
            state_d[i] = IDLE;
          end
        end
        default: begin
          rcnt_d[i]  = '0;
          state_d[i] = IDLE;
        end
      endcase
    end
  end

  // Opposing directions firing together cancel each other at the output only.
  always_comb begin
    pulse_d         = '0;
    pulse_d[CH_L]   = fire_d[CH_L] & ~fire_d[CH_R];
    pulse_d[CH_R]   = fire_d[CH_R] & ~fire_d[CH_L];
    pulse_d[CH_U]   = fire_d[CH_U] & ~fire_d[CH_D];
    pulse_d[CH_D]   = fire_d[CH_D] & ~fire_d[CH_U];
    pulse_d[CH_SEL] = fire_d[CH_SEL];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      fire_q   <= '0;
      pulse_q  <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        dcnt_q[i]  <= '0;
        rcnt_q[i]  <= '0;
        state_q[i] <= IDLE;
      end
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      fire_q   <= fire_d;
      pulse_q  <= pulse_d;
      for (int unsigned i = 0; i < NCH; i++) begin
        dcnt_q[i]  <= dcnt_d[i];
        rcnt_q[i]  <= rcnt_d[i];
        state_q[i] <= state_d[i];
      end
    end
  end

  assign btn.left_p    = pulse_q[CH_L];
  assign btn.right_p   = pulse_q[CH_R];
  assign btn.up_p      = pulse_q[CH_U];
  assign btn.down_p    = pulse_q[CH_D];
  assign btn.sel_p     = pulse_q[CH_SEL];
  assign btn.btn_state = stable_q;

endmodule
